// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, instruction fields and FSM encoding for alu_ctrl
package alu_pkg;

  localparam int OP_LSB  = 0;
  localparam int OP_MSB  = 2;
  localparam int WB_BIT  = 3;
  localparam int RSV_LSB = 4;
  localparam int RSV_MSB = 7;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_DEC = 3'b010,
    OP_INC = 3'b011,
    OP_OC  = 3'b100,
    OP_BND = 3'b101,
    OP_BOR = 3'b110,
    OP_BXR = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OPND   = 2'd1,
    S_EXEC   = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  // Two-operand ops need a B operand byte fetched before execution.
  function automatic logic uses_b(input op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_BND, OP_BOR, OP_BXR: uses_b = 1'b1;
      default:                                uses_b = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_ctrl.sv
// rtl/alu_ctrl.sv - byte-fed ALU sequencer: decode, operand fetch, execute, result strobe
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int INSTR_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [INSTR_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [2:0]         alu_op,
  output logic               alu_oe,
  output logic               breg_load,
  output logic               acc_load,
  output logic               done,
  output logic               err,
  output logic [7:0]         instr_count
);

  state_t     state, state_nxt;
  op_t        op_q;
  logic       wb_q;
  logic       err_q;
  logic [7:0] count_q;

  logic handshake;
  logic illegal;
  op_t  in_op;

  assign in_ready  = !RST && (state == S_IDLE || state == S_OPND);
  assign handshake = in_valid && in_ready;
  assign illegal   = |in_data[RSV_MSB:RSV_LSB];
  assign in_op     = op_t'(in_data[OP_MSB:OP_LSB]);

  always_comb begin
    state_nxt = state;
    breg_load = 1'b0;
    alu_oe    = 1'b0;
    acc_load  = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (handshake && !illegal)
          state_nxt = uses_b(in_op) ? S_OPND : S_EXEC;
      end
      S_OPND: begin
        breg_load = in_valid && !RST;
        if (handshake)
          state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_RESULT;
      end
      S_RESULT: begin
        alu_oe    = 1'b1;
        acc_load  = wb_q;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      op_q    <= OP_ADD;
      wb_q    <= 1'b0;
      err_q   <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state <= state_nxt;
      err_q <= (state == S_IDLE) && handshake && illegal;
      // Op/WB only move on a legal decode so alu_op holds between instructions.
      if (state == S_IDLE && handshake && !illegal) begin
        op_q <= in_op;
        wb_q <= in_data[WB_BIT];
      end
      if (state == S_RESULT)
        count_q <= count_q + 8'd1;
    end
  end

  assign alu_op      = op_q;
  assign err         = err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb/tb_alu_ctrl.sv - vector-table and sequence checks for alu_ctrl
module tb_alu_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] alu_op;
  logic       alu_oe, breg_load, acc_load, done, err;
  logic [7:0] instr_count;

  always #5 CLK = ~CLK;

  alu_ctrl #(.INSTR_W(8)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_op      (alu_op),
    .alu_oe      (alu_oe),
    .breg_load   (breg_load),
    .acc_load    (acc_load),
    .done        (done),
    .err         (err),
    .instr_count (instr_count)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic [16:0] expect_out;
  } vec_t;

  vec_t tbl[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   done_pulses = 0;
  int   overlap     = 0;

  // Output bundle: {in_ready, alu_op, alu_oe, breg_load, acc_load, done, err, instr_count}
  function automatic logic [16:0] obs();
    return {in_ready, alu_op, alu_oe, breg_load, acc_load, done, err, instr_count};
  endfunction

  task automatic add(input logic rst, input logic v, input logic [7:0] d,
                     input logic rdy, input logic [2:0] op, input logic oe,
                     input logic bl, input logic al, input logic dn,
                     input logic er, input logic [7:0] cnt);
    vec_t t;
    t.rst        = rst;
    t.valid      = v;
    t.data       = d;
    t.expect_out = {rdy, op, oe, bl, al, dn, er, cnt};
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    #1;
    if (done) done_pulses++;
    if (done && err) overlap++;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //   rst v  data   rdy op    oe bl al dn er cnt
    add(1, 0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 0, 8'd0);  // in reset
    add(1, 1, 8'h0B, 0, 3'd0, 0, 0, 0, 0, 0, 8'd0);  // ready held low in reset
    add(0, 1, 8'h0B, 1, 3'd0, 0, 0, 0, 0, 0, 8'd0);  // INC accepted on first edge
    add(0, 0, 8'h00, 0, 3'd3, 0, 0, 0, 0, 0, 8'd0);  // EXEC
    add(0, 0, 8'h00, 0, 3'd3, 1, 0, 1, 1, 0, 8'd0);  // RESULT
    add(0, 0, 8'h00, 1, 3'd3, 0, 0, 0, 0, 0, 8'd1);  // IDLE, count 1
    add(0, 1, 8'h08, 1, 3'd3, 0, 0, 0, 0, 0, 8'd1);  // ADD+WB accepted
    add(0, 0, 8'h00, 1, 3'd0, 0, 0, 0, 0, 0, 8'd1);  // OPND stall 1
    add(0, 0, 8'h00, 1, 3'd0, 0, 0, 0, 0, 0, 8'd1);  // OPND stall 2
    add(0, 0, 8'h00, 1, 3'd0, 0, 0, 0, 0, 0, 8'd1);  // OPND stall 3
    add(0, 1, 8'h05, 1, 3'd0, 0, 1, 0, 0, 0, 8'd1);  // operand, breg_load
    add(0, 0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 0, 8'd1);  // EXEC
    add(0, 0, 8'h00, 0, 3'd0, 1, 0, 1, 1, 0, 8'd1);  // RESULT
    add(0, 1, 8'h18, 1, 3'd0, 0, 0, 0, 0, 0, 8'd2);  // illegal byte
    add(0, 0, 8'h00, 1, 3'd0, 0, 0, 0, 0, 1, 8'd2);  // err pulse, op unchanged
    add(0, 0, 8'h00, 1, 3'd0, 0, 0, 0, 0, 0, 8'd2);  // err gone
    add(0, 1, 8'h01, 1, 3'd0, 0, 0, 0, 0, 0, 8'd2);  // SUB no WB
    add(0, 1, 8'h33, 1, 3'd1, 0, 1, 0, 0, 0, 8'd2);  // operand
    add(0, 1, 8'h0B, 0, 3'd1, 0, 0, 0, 0, 0, 8'd2);  // EXEC, byte ignored
    add(0, 1, 8'h0B, 0, 3'd1, 1, 0, 0, 1, 0, 8'd2);  // RESULT, acc_load=0
    add(0, 1, 8'h0B, 1, 3'd1, 0, 0, 0, 0, 0, 8'd3);  // INC taken in IDLE
    add(0, 0, 8'h00, 0, 3'd3, 0, 0, 0, 0, 0, 8'd3);  // EXEC
    add(0, 0, 8'h00, 0, 3'd3, 1, 0, 1, 1, 0, 8'd3);  // RESULT
    add(0, 0, 8'h00, 1, 3'd3, 0, 0, 0, 0, 0, 8'd4);  // IDLE
    add(0, 1, 8'h0F, 1, 3'd3, 0, 0, 0, 0, 0, 8'd4);  // BXR+WB
    add(0, 1, 8'h77, 1, 3'd7, 0, 1, 0, 0, 0, 8'd4);  // operand
    add(0, 0, 8'h00, 0, 3'd7, 0, 0, 0, 0, 0, 8'd4);  // EXEC
    add(1, 0, 8'h00, 0, 3'd0, 0, 0, 0, 0, 0, 8'd0);  // async reset in RESULT slot
    add(0, 0, 8'h00, 1, 3'd0, 0, 0, 0, 0, 0, 8'd0);  // released, no done
    add(0, 0, 8'h00, 1, 3'd0, 0, 0, 0, 0, 0, 8'd0);
    add(0, 1, 8'h0A, 1, 3'd0, 0, 0, 0, 0, 0, 8'd0);  // DEC+WB
    add(0, 0, 8'h00, 0, 3'd2, 0, 0, 0, 0, 0, 8'd0);  // EXEC
    add(0, 0, 8'h00, 0, 3'd2, 1, 0, 1, 1, 0, 8'd0);  // RESULT
    add(0, 0, 8'h00, 1, 3'd2, 0, 0, 0, 0, 0, 8'd1);  // IDLE, count 1

    // EXEC of BXR is the vector before the reset; reset lands mid-cycle there.
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst && i > 1) begin
        RST      = 1'b0;
        in_valid = tbl[i].valid;
        in_data  = tbl[i].data;
        #2;
        RST = 1'b1;
      end else begin
        RST      = tbl[i].rst;
        in_valid = tbl[i].valid;
        in_data  = tbl[i].data;
      end
      #1;
      check($sformatf("vec%0d", i), {15'd0, obs()}, {15'd0, tbl[i].expect_out});
      @(posedge CLK);
      #1;
    end

    // 256 back-to-back OC instructions from a clean reset.
    RST = 1'b1;
    in_valid = 1'b0;
    #1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    done_pulses = 0;
    overlap     = 0;
    for (int k = 0; k < 256; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h0C;
      cyc();
      in_valid = 1'b0;
      cyc();
      cyc();
      if (k == 254) check("count_255", {24'd0, instr_count}, 32'd255);
      if (k == 0)   check("oc_op", {29'd0, alu_op}, 32'd4);
    end
    check("count_wrap", {24'd0, instr_count}, 32'd0);
    check("done_pulses", done_pulses, 256);
    check("err_done_overlap", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
